// File: rtl/count_bcd_sink_if.sv
// Single-beat AXI-stream style channel carrying the pulse count
// into the BCD sink.
interface axi_if #(
    parameter int DATA_W = 32
) ();
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/count_bcd_sink.sv
// Pulse-count stream sink: saturates the count, converts it to packed
// BCD with an iterative double-dabble engine and holds it for display.
module count_bcd_sink #(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 16,
    parameter int DIGITS  = 5
) (
    input  logic                clk,
    input  logic                rst,
    axi_if.slave                axi,
    output logic [4*DIGITS-1:0] bcd,
    output logic                bcd_valid,
    output logic                overflow,
    output logic                busy
);
    localparam int IW = $clog2(COUNT_W + 1);
    localparam int BW = 4 * DIGITS;

    function automatic int dec_digits(input int w);
        longint v;
        int     n;
        v = (longint'(1) << w) - 1;
        n = 0;
        while (v > 0) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

    if (dec_digits(COUNT_W) > DIGITS) begin : g_digits_chk
        $error("DIGITS too small for COUNT_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        iter_q, iter_d;
    logic [COUNT_W-1:0]   bin_q, bin_d;
    logic [BW-1:0]        scr_q, scr_d;
    logic                 ovf_q, ovf_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic                 ovfo_q, ovfo_d;
    logic                 valid_q, valid_d;

    logic                 accept;
    logic                 hi_nz;
    logic [COUNT_W-1:0]   operand;
    logic [BW-1:0]        corr;
    logic                 unused_tlast;

    // Packets are single-beat, so tlast carries no information here.
    assign unused_tlast = axi.tlast;

    assign axi.tready = (state_q == IDLE) && !rst;
    assign accept     = axi.tvalid && axi.tready;
    assign hi_nz      = |axi.tdata[DATA_W-1:COUNT_W];
    assign operand    = hi_nz ? {COUNT_W{1'b1}} : axi.tdata[COUNT_W-1:0];

    always_comb begin
        corr = scr_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scr_q[4*d +: 4] >= 4'd5) begin
                corr[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        ovfo_d  = ovfo_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CONVERT;
                    bin_d   = operand;
                    scr_d   = '0;
                    iter_d  = '0;
                    ovf_d   = hi_nz;
                end
            end
            CONVERT: begin
                {scr_d, bin_d} = {corr, bin_q} << 1;
                iter_d = iter_q + 1'b1;
                if (iter_q == IW'(COUNT_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scr_q;
                ovfo_d  = ovf_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
            ovfo_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
            ovfo_q  <= ovfo_d;
            valid_q <= valid_d;
        end
    end

    assign bcd       = bcd_q;
    assign overflow  = ovfo_q;
    assign bcd_valid = valid_q;
    assign busy      = (state_q != IDLE);
endmodule
